// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared opcode and state definitions for the sequential ALU
//
// Purpose: SELECT opcode constants and FSM state encoding used by alu_seq
//          and alu_logic_comb.
// Ports:   none (package).

package alu_defs;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_logic_comb.sv
// rtl/alu_logic_comb.sv - combinational FWD/ADD/AND/OR/SUB unit
//
// Purpose: single-cycle ALU operations, WIDTH-parametrised.
// Ports:
//   sel  in   3      opcode (alu_defs OP_*)
//   a    in   WIDTH  operand A
//   b    in   WIDTH  operand B
//   y    out  WIDTH  result; zero for MUL and reserved opcodes

module alu_logic_comb
  import alu_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Add/subtract wrap silently modulo 2^WIDTH; no carry is exported.
  always_comb begin
    y = '0;
    case (sel)
      OP_FWD:  y = b;
      OP_ADD:  y = a + b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SUB:  y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with iterative multiply and valid/ready handshakes
//
// Purpose: accepts one operation when idle, produces a registered RESULT/ZERO
//          one cycle later (single-cycle ops) or after WIDTH shift-add
//          iterations (MUL), and holds it until the consumer takes it.
// Ports:
//   CLK        in   1      rising-edge clock
//   RESET      in   1      asynchronous active-low reset
//   IN_VALID   in   1      operands and SELECT valid
//   IN_READY   out  1      high in IDLE
//   SELECT     in   3      opcode
//   DATA1      in   WIDTH  operand A
//   DATA2      in   WIDTH  operand B
//   OUT_VALID  out  1      high in DONE
//   OUT_READY  in   1      consumer takes the result (DONE only)
//   RESULT     out  WIDTH  registered result
//   ZERO       out  1      registered RESULT == 0
//   BUSY       out  1      high in MUL

module alu_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] logic_y;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             mul_last;

  alu_logic_comb #(.WIDTH(WIDTH)) u_logic (
    .sel (SELECT),
    .a   (DATA1),
    .b   (DATA2),
    .y   (logic_y)
  );

  // Partial product for the current iteration; truncation makes the product
  // identical for signed and unsigned operands.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    BUSY       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        accept   = IN_VALID;
        if (IN_VALID) next_state = (SELECT == OP_MUL) ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        BUSY = 1'b1;
        if (mul_last) next_state = ST_DONE;
      end
      ST_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operands are captured only at accept, so later input changes are ignored.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RESULT <= '0;
      ZERO   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (SELECT == OP_MUL) begin
              mcand  <= DATA1;
              mplier <= DATA2;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              RESULT <= logic_y;
              ZERO   <= (logic_y == '0);
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) begin
            RESULT <= acc_next;
            ZERO   <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=8)

module tb_alu_seq;

  logic       CLK;
  logic       RESET;
  logic       IN_VALID;
  logic       IN_READY;
  logic [2:0] SELECT;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] RESULT;
  logic       ZERO;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .SELECT    (SELECT),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .ZERO      (ZERO),
    .BUSY      (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Called just after a falling edge; presents one operation for one rising
  // edge and returns at the falling edge after it (cycle 1 after accept).
  task automatic start_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    IN_VALID = 1'b1;
    SELECT   = sel;
    DATA1    = a;
    DATA2    = b;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    IN_VALID = 1'b0; SELECT = 3'b000; DATA1 = 8'h00; DATA2 = 8'h00; OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || BUSY !== 1'b0 || RESULT !== 8'h00 || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h zero=%b, required 1 0 0 00 0",
               IN_READY, OUT_VALID, BUSY, RESULT, ZERO);
    end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_and;
    OUT_READY = 1'b1;
    start_op(3'b010, 8'hD4, 8'h0A);
    checks++;
    if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || RESULT !== 8'h00 || ZERO !== 1'b1) begin
      errors++;
      $display("FAIL and_zero: out_valid=%b in_ready=%b result=%h zero=%b, required 1 0 00 1",
               OUT_VALID, IN_READY, RESULT, ZERO);
    end
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL and_return_idle: in_ready=%b out_valid=%b, required 1 0", IN_READY, OUT_VALID);
    end
    start_op(3'b010, 8'd15, 8'd11);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'd11 || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL and_nonzero: out_valid=%b result=%0d zero=%b, required 1 11 0", OUT_VALID, RESULT, ZERO);
    end
    @(negedge CLK);
  endtask

  task automatic test_arith;
    start_op(3'b001, 8'd100, 8'd200);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'd44 || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap: out_valid=%b result=%0d zero=%b, required 1 44 0", OUT_VALID, RESULT, ZERO);
    end
    @(negedge CLK);
    start_op(3'b101, 8'd5, 8'd7);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'hFE || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: out_valid=%b result=%h zero=%b, required 1 fe 0", OUT_VALID, RESULT, ZERO);
    end
    @(negedge CLK);
    start_op(3'b000, 8'h33, 8'h5A);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'h5A || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL fwd: out_valid=%b result=%h zero=%b, required 1 5a 0", OUT_VALID, RESULT, ZERO);
    end
    @(negedge CLK);
    start_op(3'b111, 8'h12, 8'h34);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'h00 || ZERO !== 1'b1) begin
      errors++;
      $display("FAIL reserved: out_valid=%b result=%h zero=%b, required 1 00 1", OUT_VALID, RESULT, ZERO);
    end
    @(negedge CLK);
  endtask

  task automatic test_mul;
    OUT_READY = 1'b1;
    start_op(3'b100, 8'd13, 8'd11);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (BUSY !== 1'b1 || IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy cycle %0d: busy=%b in_ready=%b out_valid=%b, required 1 0 0",
                 i + 1, BUSY, IN_READY, OUT_VALID);
      end
      @(negedge CLK);
    end
    checks++;
    if (OUT_VALID !== 1'b1 || BUSY !== 1'b0 || RESULT !== 8'd143 || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL mul_13x11: out_valid=%b busy=%b result=%0d zero=%b, required 1 0 143 0",
               OUT_VALID, BUSY, RESULT, ZERO);
    end
    @(negedge CLK);
    start_op(3'b100, 8'd20, 8'd20);
    repeat (8) @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'd144) begin
      errors++;
      $display("FAIL mul_20x20: out_valid=%b result=%0d, required 1 144", OUT_VALID, RESULT);
    end
    @(negedge CLK);
    start_op(3'b100, 8'hFD, 8'd5);
    repeat (8) @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'hF1) begin
      errors++;
      $display("FAIL mul_neg3x5: out_valid=%b result=%h, required 1 f1", OUT_VALID, RESULT);
    end
    @(negedge CLK);
  endtask

  task automatic test_backpressure;
    OUT_READY = 1'b0;
    start_op(3'b011, 8'h0F, 8'hF0);
    IN_VALID = 1'b1;
    SELECT   = 3'b001;
    DATA1    = 8'd1;
    DATA2    = 8'd1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || RESULT !== 8'hFF || ZERO !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b result=%h zero=%b, required 1 0 ff 0",
                 i, OUT_VALID, IN_READY, RESULT, ZERO);
      end
      @(negedge CLK);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || RESULT !== 8'hFF) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b result=%h, required 1 0 ff",
               IN_READY, OUT_VALID, RESULT);
    end
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0 || RESULT !== 8'hFF) begin
      errors++;
      $display("FAIL backpressure_no_accept: out_valid=%b result=%h, required 0 ff", OUT_VALID, RESULT);
    end
  endtask

  task automatic test_operand_change;
    OUT_READY = 1'b1;
    start_op(3'b100, 8'd3, 8'd4);
    DATA1 = 8'hFF;
    DATA2 = 8'hFF;
    repeat (8) @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'd12) begin
      errors++;
      $display("FAIL operand_change: out_valid=%b result=%0d, required 1 12", OUT_VALID, RESULT);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_mul;
    OUT_READY = 1'b1;
    start_op(3'b100, 8'd13, 8'd11);
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 8'h00 || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: out_valid=%b busy=%b in_ready=%b result=%h zero=%b, required 0 0 1 00 0",
               OUT_VALID, BUSY, IN_READY, RESULT, ZERO);
    end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_output: out_valid=%b busy=%b, required 0 0", OUT_VALID, BUSY);
    end
    start_op(3'b001, 8'd1, 8'd1);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 8'd2 || ZERO !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset: out_valid=%b result=%0d zero=%b, required 1 2 0", OUT_VALID, RESULT, ZERO);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_and;
    test_arith;
    test_mul;
    test_backpressure;
    test_operand_change;
    test_reset_mid_mul;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
